// File: rtl/ex_mem_stage_register_pkg.sv
// Shared definitions for the EX stage: datapath widths and the op-select
// encoding used by the ID/EX, EX and MEM stages.
package ex_mem_stage_register_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int COUNT_WIDTH    = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADDI = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5
    } op_sel_e;

    // Priority decode of the one-hot-ish ID/EX controls: addi > add > sub > lw > sw.
    function automatic op_sel_e decode_op(
        input logic addi,
        input logic add,
        input logic sub,
        input logic lw,
        input logic sw
    );
        op_sel_e op;
        if (addi) begin
            op = OP_ADDI;
        end else if (add) begin
            op = OP_ADD;
        end else if (sub) begin
            op = OP_SUB;
        end else if (lw) begin
            op = OP_LW;
        end else if (sw) begin
            op = OP_SW;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/ex_mem_stage_register_alu.sv
// Combinational EX ALU: addi/add/sub results with signed-overflow detection,
// and address generation for lw/sw (which never traps).
module ex_alu_overflow
    import ex_mem_stage_register_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_sel_e          i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_result;
    logic             w_overflow;

    // Select the operation; overflow is judged purely from operand/result sign bits.
    always_comb begin
        w_result   = {WIDTH{1'b0}};
        w_overflow = 1'b0;
        case (i_op)
            OP_ADDI: begin
                w_result   = i_rs + i_imm;
                w_overflow = (i_rs[WIDTH-1] == i_imm[WIDTH-1]) &&
                             (w_result[WIDTH-1] != i_rs[WIDTH-1]);
            end
            OP_ADD: begin
                w_result   = i_rs + i_rt;
                w_overflow = (i_rs[WIDTH-1] == i_rt[WIDTH-1]) &&
                             (w_result[WIDTH-1] != i_rs[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = i_rs - i_rt;
                w_overflow = (i_rs[WIDTH-1] != i_rt[WIDTH-1]) &&
                             (w_result[WIDTH-1] != i_rs[WIDTH-1]);
            end
            OP_LW, OP_SW: begin
                w_result   = i_rs + i_imm;
                w_overflow = 1'b0;
            end
            default: begin
                w_result   = {WIDTH{1'b0}};
                w_overflow = 1'b0;
            end
        endcase
    end

    assign o_result   = w_result;
    assign o_overflow = w_overflow;

endmodule

// File: rtl/ex_mem_stage_register.sv
// EX stage plus EX/MEM pipeline register: runs the ALU on the ID/EX operands,
// turns signed overflow into a one-cycle trap pulse that suppresses write-back,
// and registers result/control for MEM with flush > stall > load priority.
module ex_mem_stage_register #(
    parameter int DATA_WIDTH     = ex_mem_stage_register_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ex_mem_stage_register_pkg::REG_ADDR_WIDTH,
    parameter int COUNT_WIDTH    = ex_mem_stage_register_pkg::COUNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      signal_addi,
    input  logic                      signal_add,
    input  logic                      signal_sub,
    input  logic                      signal_lw,
    input  logic                      signal_sw,
    input  logic                      signal_regwrite,
    input  logic [DATA_WIDTH-1:0]     rs_data,
    input  logic [DATA_WIDTH-1:0]     rt_data,
    input  logic [DATA_WIDTH-1:0]     imm_sext,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    output logic                      out_valid_reg,
    output logic [DATA_WIDTH-1:0]     out_alu_result_reg,
    output logic [DATA_WIDTH-1:0]     out_store_data_reg,
    output logic [REG_ADDR_WIDTH-1:0] out_dest_reg,
    output logic                      out_regwrite_reg,
    output logic                      out_memread_reg,
    output logic                      out_memwrite_reg,
    output logic                      out_overflow_reg,
    output logic [COUNT_WIDTH-1:0]    overflow_count
);

    import ex_mem_stage_register_pkg::*;

    op_sel_e                   w_op;
    logic [DATA_WIDTH-1:0]     w_alu_result;
    logic                      w_alu_overflow;
    logic                      w_trap;
    logic                      w_load;

    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_alu_result;
    logic [DATA_WIDTH-1:0]     r_store_data;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic                      r_regwrite;
    logic                      r_memread;
    logic                      r_memwrite;
    logic                      r_overflow;
    logic [COUNT_WIDTH-1:0]    r_overflow_count;

    assign w_op   = decode_op(signal_addi, signal_add, signal_sub, signal_lw, signal_sw);
    // A bubble in ID/EX can never raise a trap, whatever its operands.
    assign w_trap = w_alu_overflow & in_valid;
    assign w_load = ~flush & ~stall;

    ex_alu_overflow #(
        .WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_op       (w_op),
        .i_rs       (rs_data),
        .i_rt       (rt_data),
        .i_imm      (imm_sext),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow)
    );

    // EX/MEM register: reset > flush (kill controls, hold data) > stall (hold, drop trap) > load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_alu_result <= {DATA_WIDTH{1'b0}};
            r_store_data <= {DATA_WIDTH{1'b0}};
            r_dest       <= {REG_ADDR_WIDTH{1'b0}};
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_overflow <= 1'b0;
        end else if (stall) begin
            r_overflow <= 1'b0;
        end else begin
            r_valid      <= in_valid;
            r_alu_result <= w_alu_result;
            r_store_data <= rt_data;
            r_dest       <= dest_reg;
            if (w_trap) begin
                r_overflow <= 1'b1;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                r_overflow <= 1'b0;
                r_regwrite <= signal_regwrite & in_valid;
                r_memread  <= signal_lw & in_valid;
                r_memwrite <= signal_sw & in_valid;
            end
        end
    end

    // Saturating trap counter: advances only when a trapping instruction is loaded.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_count <= {COUNT_WIDTH{1'b0}};
        end else if (w_load && w_trap && (r_overflow_count != {COUNT_WIDTH{1'b1}})) begin
            r_overflow_count <= r_overflow_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_overflow_count <= r_overflow_count;
        end
    end

    assign out_valid_reg      = r_valid;
    assign out_alu_result_reg = r_alu_result;
    assign out_store_data_reg = r_store_data;
    assign out_dest_reg       = r_dest;
    assign out_regwrite_reg   = r_regwrite;
    assign out_memread_reg    = r_memread;
    assign out_memwrite_reg   = r_memwrite;
    assign out_overflow_reg   = r_overflow;
    assign overflow_count     = r_overflow_count;

endmodule
